// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg
//   Shared definitions for the round-robin mux arbiter: requester count,
//   selector width, FSM state encoding and a one-hot to index helper.
//   No ports (package).
package mux_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Index of the set bit of a one-hot vector; returns 0 for an all-zero vector.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// mux_arbiter_rr_pick
//   Combinational rotating-priority picker. Scans the eligible requests
//   (req with mask bits removed) starting at ptr and wrapping, and reports
//   the first one found.
// Ports
//   req   in  4  request vector
//   mask  in  4  bits to exclude from this pick
//   ptr   in  2  highest-priority position
//   found out 1  at least one eligible request
//   idx   out 2  index of the winner (valid when found)
module mux_arbiter_rr_pick
  import mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] elig;
  logic [SEL_W-1:0]   cand;

  always_comb begin
    elig  = req & ~mask;
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      // SEL_W-bit addition wraps 3 -> 0 naturally
      cand = ptr + SEL_W'(i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter
//   Round-robin arbiter sharing one 4:1 16-bit mux among four requesters.
//   Grants one requester at a time (registered one-hot grant) and drives the
//   mux selector. A releasing owner hands over back-to-back to the next
//   requester in rotation with no dead cycle.
// Optional feature
//   ARB_TIMEOUT_EN : when defined, an owner that has held the grant for
//   MAX_HOLD cycles is preempted if anyone else is requesting; preempt pulses
//   for the cycle the new grant appears. Undefined: no preemption, preempt=0.
// Parameters
//   MAX_HOLD  max consecutive grant cycles before preemption (timeout build)
//   CNT_WIDTH hold-counter width, must hold MAX_HOLD-1
// Ports
//   clk      in  1  clock, rising edge
//   rst      in  1  synchronous reset, active-high
//   req      in  4  request per requester, held until served
//   grant    out 4  one-hot grant, registered
//   selector out 2  index of current/last grantee, registered
//   busy     out 1  any grant active
//   preempt  out 1  1-cycle pulse when a grant is revoked by timeout
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD  = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   selector,
  output logic               busy,
  output logic               preempt
);

  if (MAX_HOLD < 1 || CNT_WIDTH < 1 || (MAX_HOLD - 1) >= (1 << CNT_WIDTH)) begin : g_bad_params
    $error("mux_arbiter: CNT_WIDTH too small for MAX_HOLD");
  end

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [SEL_W-1:0]   sel_n;

  logic [SEL_W-1:0]   owner;
  logic [SEL_W-1:0]   owner_nxt;
  logic [NUM_REQ-1:0] own_mask;
  logic [SEL_W-1:0]   pick_ptr;
  logic               found;
  logic [SEL_W-1:0]   win;
  logic               timeout;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);
  logic [CNT_WIDTH-1:0] hold_cnt, hold_n;
  logic                 preempt_n;
`endif

  // While granted, the owner is masked and the scan starts just past it, so
  // a requester re-asserting in its own release cycle cannot win again.
  assign owner     = onehot_to_idx(grant);
  assign owner_nxt = owner + SEL_W'(1);
  assign own_mask  = (state == ST_GRANT) ? (NUM_REQ'(1) << owner) : '0;
  assign pick_ptr  = (state == ST_GRANT) ? owner_nxt : ptr;
  assign busy      = |grant;

`ifdef ARB_TIMEOUT_EN
  assign timeout = (state == ST_GRANT) && (hold_cnt == HOLD_LAST) && (|(req & ~own_mask));
`else
  assign timeout = 1'b0;
`endif

  mux_arbiter_rr_pick u_rr_pick (
    .req   (req),
    .mask  (own_mask),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant;
    sel_n   = selector;
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_n = NUM_REQ'(1) << win;
          sel_n   = win;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[owner] || timeout) begin
          ptr_n = owner_nxt;
          if (found) begin
            grant_n = NUM_REQ'(1) << win;
            sel_n   = win;
          end else begin
            // selector keeps the last grantee so the mux output stays stable
            grant_n = '0;
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        grant_n = '0;
        state_n = ST_IDLE;
      end
    endcase

`ifdef ARB_TIMEOUT_EN
    // A timeout always has another requester, so it always hands over.
    preempt_n = timeout & req[owner];
    if (state_n != ST_GRANT || grant_n != grant) begin
      hold_n = '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_n = hold_cnt + CNT_WIDTH'(1);
    end else begin
      hold_n = hold_cnt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant    <= '0;
      selector <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      grant    <= grant_n;
      selector <= sel_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      hold_cnt <= hold_n;
      preempt  <= preempt_n;
    end
  end
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter
//   Self-checking bench for mux_arbiter. A reference model computes the
//   expected registered outputs at every rising edge and queues them; a
//   monitor on the falling edge pops and compares against the DUT.
//   Directed scenarios are followed by randomized request traffic.
module tb_mux_arbiter;

  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] selector;
  logic       busy;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  mux_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .selector (selector),
    .busy     (busy),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       pre;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or after start (wrapping), ignoring index skip.
  function automatic int first_req(input logic [3:0] r, input int start, input int skip);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (start + i) % 4;
      if (c != skip && r[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: owner index (-1 = none), rotation start, hold length.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_sel   = 0;
  bit m_pre   = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    int   j;
    int   k;
    bit   to;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_owner < 0) begin
        j = first_req(req, m_ptr, -1);
        if (j >= 0) begin m_owner = j; m_sel = j; m_hold = 0; end
      end else begin
        k  = m_owner;
        to = TO_EN && (m_hold >= MAX_HOLD - 1) && ((req & ~(4'b0001 << k)) != 4'b0000);
        if (!req[k] || to) begin
          m_ptr = (k + 1) % 4;
          j = first_req(req, m_ptr, k);
          if (j >= 0) begin
            m_pre = req[k]; m_owner = j; m_sel = j; m_hold = 0;
          end else begin
            m_owner = -1;
          end
        end else if (m_hold < MAX_HOLD - 1) begin
          m_hold++;
        end
      end
    end
    e.grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.sel   = 2'(m_sel);
    e.busy  = (m_owner >= 0);
    e.pre   = m_pre;
    sbq.push_back(e);
  end

  // Monitor-side bookkeeping for directed scenarios
  bit         phase3    = 1'b0;
  bit         p3_active = 1'b0;
  int         p3_idle   = 0;
  int         p3_order[$];
  logic [3:0] last_g    = 4'b0000;
  int         pre_seen  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty actual=0 expected=entry at %0t", $time);
    end else begin
      e = sbq.pop_front();
      check("grant",    int'(grant),    int'(e.grant));
      check("selector", int'(selector), int'(e.sel));
      check("busy",     int'(busy),     int'(e.busy));
      check("preempt",  int'(preempt),  int'(e.pre));
    end
    if (preempt) pre_seen++;
    if (phase3) begin
      if (grant != 4'b0000) p3_active = 1'b1;
      if (p3_active && !busy) p3_idle++;
      if (grant != 4'b0000 && grant != last_g) begin
        for (int i = 0; i < 4; i++) if (grant[i]) p3_order.push_back(i);
      end
    end
    last_g = grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hc[4];

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    // Reset held two cycles with all requests up
    rst = 1'b1; req = 4'b1111;
    tick(); tick();

    // Single requester 2, then release; then ptr=3 decides 3 before 0
    rst = 1'b0; req = 4'b0000; tick();
    req = 4'b0100; tick(); tick();
    req = 4'b0000; tick(); tick();
    req = 4'b1001; tick(); tick(); tick();
    req = 4'b0000; tick(); tick();

    // All requesting; each grantee drops after two cycles, then re-asserts
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b1111; phase3 = 1'b1;
    for (int i = 0; i < 4; i++) hc[i] = 0;
    repeat (14) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) begin
          hc[i]++;
          if (hc[i] >= 2) begin req[i] = 1'b0; hc[i] = 0; end
        end else begin
          req[i] = 1'b1;
        end
      end
    end
    phase3 = 1'b0;
    check("rr_order_len", (p3_order.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < p3_order.size()) check("rr_order", p3_order[i], exp_order[i]);
    end
    check("rr_idle_cycles", p3_idle, 0);

    // Reset mid-grant drops the grant; afterwards served again from ptr=0
    req = 4'b0000; rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0010; tick(); tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; tick(); tick(); tick();
    req = 4'b0000; tick(); tick();

    // Long hold by requester 0 with requester 2 joining, then lone hold
    rst = 1'b1; tick();
    rst = 1'b0; pre_seen = 0;
    req = 4'b0001; tick(); tick(); tick();
    req = 4'b0101; repeat (12) tick();
    req = 4'b0001; repeat (20) tick();
    req = 4'b0000; tick(); tick();
    check("preempt_count", pre_seen, TO_EN ? 1 : 0);

    // Randomized traffic with occasional reset; requests tend to persist
    repeat (600) begin
      tick();
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
    end
    rst = 1'b0; req = 4'b0000; tick(); tick();

    @(negedge clk);
    #1;
    check("sb_drain", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
